// File: rtl/ysyx_22050854_wb_pipe_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_wb_pipe_if
// This interface carries the MEM -> WB retire handshake for the RV64
// write-back stage.
//   in_valid    : MEM presents an instruction
//   in_ready    : WB can accept this cycle
//   in_pc       : instruction PC
//   in_alu      : ALU result
//   in_mem      : load data, already aligned to bit 0
//   in_csr      : CSR read value
//   in_wbsel    : result source (0 ALU, 1 MEM, 2 PC+4, 3 CSR)
//   in_size     : load size (0 B, 1 H, 2 W, 3 D)
//   in_unsigned : zero-extend the load
//   in_regwr    : instruction writes rd
//   in_rd       : destination register
// The master modport is the MEM stage side. The slave modport is the WB side.
// ---------------------------------------------------------------------------
interface ysyx_22050854_wb_pipe_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_mem;
    logic [XLEN-1:0] in_csr;
    logic [1:0]      in_wbsel;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic            in_regwr;
    logic [AW-1:0]   in_rd;

    modport master (
        output in_valid, in_pc, in_alu, in_mem, in_csr, in_wbsel,
               in_size, in_unsigned, in_regwr, in_rd,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_alu, in_mem, in_csr, in_wbsel,
               in_size, in_unsigned, in_regwr, in_rd,
        output in_ready
    );
endinterface

// File: rtl/ysyx_22050854_wb_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_22050854_wb_pipe
// This module is the pipelined write-back stage of the 5-stage RV64 core.
// It holds one retiring instruction in a single-entry WB register. It
// selects and extends the result, commits the result to the embedded integer
// register file, and counts retired instructions.
//
// Ports:
//   clk, rst_n           : core clock, asynchronous active-low reset
//   mem_if (slave)       : MEM -> WB valid/ready handshake and fields
//   hold                 : freeze commit (debug halt or downstream stall)
//   raddr1/2, rdata1/2   : combinational register-file read ports
//   commit_valid/pc/wen/rd/data : commit bus for EX forwarding and difftest
//   instret              : retired-instruction counter (wraps)
//
// Optional macro YSYX_WB_BYPASS_EN: when this macro is defined, the read
// ports return the data being committed in the same cycle (write-through).
// ---------------------------------------------------------------------------
module ysyx_22050854_wb_pipe #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CNTW = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    ysyx_22050854_wb_pipe_if.slave            mem_if,
    input  logic                              hold,
    input  logic [AW-1:0]                     raddr1,
    input  logic [AW-1:0]                     raddr2,
    output logic [XLEN-1:0]                   rdata1,
    output logic [XLEN-1:0]                   rdata2,
    output logic                              commit_valid,
    output logic [XLEN-1:0]                   commit_pc,
    output logic                              commit_wen,
    output logic [AW-1:0]                     commit_rd,
    output logic [XLEN-1:0]                   commit_data,
    output logic [CNTW-1:0]                   instret
);

    // NREG is compared with an AW-bit address. One extra bit is needed so
    // that NREG == 2**AW can be represented.
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    // This function extends the aligned load data to XLEN. A signed cast
    // replicates the top bit of the selected field.
    function automatic logic [XLEN-1:0] f_load_ext(
        input logic [XLEN-1:0] mem,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] v;
        case (size)
            2'd0: begin
                if (uns) v = XLEN'(mem[7:0]);
                else     v = XLEN'($signed(mem[7:0]));
            end
            2'd1: begin
                if (uns) v = XLEN'(mem[15:0]);
                else     v = XLEN'($signed(mem[15:0]));
            end
            2'd2: begin
                if (uns) v = XLEN'(mem[31:0]);
                else     v = XLEN'($signed(mem[31:0]));
            end
            default: v = mem;
        endcase
        return v;
    endfunction

    logic            r_wb_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_mem;
    logic [XLEN-1:0] r_csr;
    logic [1:0]      r_wbsel;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic            r_regwr;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_rf [NREG];
    logic [CNTW-1:0] r_instret;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_commit;
    logic            w_commit_wen;
    logic [XLEN-1:0] w_result;

    // The stage can accept a new instruction when the entry is empty or
    // when the entry retires in this cycle.
    assign w_in_ready   = !r_wb_valid || !hold;
    assign w_accept     = mem_if.in_valid && w_in_ready;
    assign w_commit     = r_wb_valid && !hold;
    assign w_commit_wen = w_commit && r_regwr && (r_rd != '0);

    assign mem_if.in_ready = w_in_ready;
    assign commit_valid    = w_commit;
    assign commit_pc       = r_pc;
    assign commit_wen      = w_commit_wen;
    assign commit_rd       = r_rd;
    assign commit_data     = w_result;
    assign instret         = r_instret;

    // This block selects the result source from the captured entry.
    always_comb begin
        w_result = '0;
        case (r_wbsel)
            2'd0:    w_result = r_alu;
            2'd1:    w_result = f_load_ext(r_mem, r_size, r_unsigned);
            2'd2:    w_result = r_pc + XLEN'(3'd4);
            2'd3:    w_result = r_csr;
            default: w_result = r_alu;
        endcase
    end

    // This block drives read port 1. x0 and out-of-range addresses read as zero.
    always_comb begin
        rdata1 = '0;
        if ((raddr1 != '0) && ({1'b0, raddr1} < NREG_W)) begin
            rdata1 = r_rf[raddr1];
`ifdef YSYX_WB_BYPASS_EN
            if (w_commit_wen && (raddr1 == r_rd)) begin
                rdata1 = w_result;
            end else begin
                rdata1 = r_rf[raddr1];
            end
`endif
        end else begin
            rdata1 = '0;
        end
    end

    // This block drives read port 2. It follows the same rules as port 1.
    always_comb begin
        rdata2 = '0;
        if ((raddr2 != '0) && ({1'b0, raddr2} < NREG_W)) begin
            rdata2 = r_rf[raddr2];
`ifdef YSYX_WB_BYPASS_EN
            if (w_commit_wen && (raddr2 == r_rd)) begin
                rdata2 = w_result;
            end else begin
                rdata2 = r_rf[raddr2];
            end
`endif
        end else begin
            rdata2 = '0;
        end
    end

    // This block implements the WB entry valid flag. A transfer sets the
    // flag. A commit without a transfer clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
        end else if (w_accept) begin
            r_wb_valid <= 1'b1;
        end else if (w_commit) begin
            r_wb_valid <= 1'b0;
        end
    end

    // This block holds the WB entry fields. They load only on a transfer, so
    // a held entry stays unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_alu      <= '0;
            r_mem      <= '0;
            r_csr      <= '0;
            r_wbsel    <= 2'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_regwr    <= 1'b0;
            r_rd       <= '0;
        end else if (w_accept) begin
            r_pc       <= mem_if.in_pc;
            r_alu      <= mem_if.in_alu;
            r_mem      <= mem_if.in_mem;
            r_csr      <= mem_if.in_csr;
            r_wbsel    <= mem_if.in_wbsel;
            r_size     <= mem_if.in_size;
            r_unsigned <= mem_if.in_unsigned;
            r_regwr    <= mem_if.in_regwr;
            r_rd       <= mem_if.in_rd;
        end
    end

    // This block implements the integer register file write port. x0 is
    // never written because commit_wen excludes rd == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_commit_wen) begin
            r_rf[r_rd] <= w_result;
        end
    end

    // This block implements the retired-instruction counter. It wraps
    // naturally at 2**CNTW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_commit) begin
            r_instret <= r_instret + CNTW'(1'b1);
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050854_wb_pipe
// This is a self-checking bench for the write-back stage. It uses a table of
// retiring instructions with constant expected results. A scoreboard queue is
// filled when an instruction is driven and drained on commit_valid. A shadow
// register file supplies the expected read-port data. Hand-written sequences
// cover hold, mid-cycle reset and back-to-back streaming. The bench expects
// write-through reads when YSYX_WB_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
module tb_ysyx_22050854_wb_pipe;

    typedef struct {
        string       name;
        logic [1:0]  wbsel;
        logic [1:0]  size;
        logic        uns;
        logic        regwr;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] mem;
        logic [63:0] csr;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] data;
        logic        wen;
        logic [4:0]  rd;
    } exp_t;

`ifdef YSYX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [63:0] rdata1;
    logic [63:0] rdata2;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        commit_wen;
    logic [4:0]  commit_rd;
    logic [63:0] commit_data;
    logic [63:0] instret;

    int          n_checks;
    int          n_errors;
    exp_t        sb_q[$];
    logic [63:0] sh[32];
    logic [63:0] exp_instret;
    vec_t        tbl[12];

    ysyx_22050854_wb_pipe_if #(.XLEN(64), .AW(5)) u_if ();

    ysyx_22050854_wb_pipe #(.XLEN(64), .NREG(32), .AW(5), .CNTW(64)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_if       (u_if),
        .hold         (hold),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_wen   (commit_wen),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] wbsel,
                                input logic [1:0] size, input logic uns,
                                input logic regwr, input logic [4:0] rd,
                                input logic [63:0] pc, input logic [63:0] alu,
                                input logic [63:0] mem, input logic [63:0] csr,
                                input logic [63:0] exp_data);
        vec_t v;
        v.name = name; v.wbsel = wbsel; v.size = size; v.uns = uns;
        v.regwr = regwr; v.rd = rd; v.pc = pc; v.alu = alu; v.mem = mem;
        v.csr = csr; v.exp_data = exp_data;
        return v;
    endfunction

    // Expected read-port value: zero for x0, else shadow or same-cycle bypass.
    function automatic logic [63:0] model_read(input logic [4:0] a, input exp_t e, input bit cv);
        if (a == 5'd0)                            return 64'd0;
        else if (BYP && cv && e.wen && a == e.rd) return e.data;
        else                                      return sh[a];
    endfunction

    // This task drives one instruction, records its expected commit and
    // waits (bounded) for the transfer edge.
    task automatic send(input vec_t v);
        int cnt;
        bit rdy;
        exp_t e;
        u_if.in_valid    = 1'b1;
        u_if.in_pc       = v.pc;
        u_if.in_alu      = v.alu;
        u_if.in_mem      = v.mem;
        u_if.in_csr      = v.csr;
        u_if.in_wbsel    = v.wbsel;
        u_if.in_size     = v.size;
        u_if.in_unsigned = v.uns;
        u_if.in_regwr    = v.regwr;
        u_if.in_rd       = v.rd;
        e.pc = v.pc; e.data = v.exp_data; e.wen = v.regwr && (v.rd != 5'd0); e.rd = v.rd;
        sb_q.push_back(e);
        cnt = 0;
        rdy = 1'b0;
        while (!rdy && cnt < 50) begin
            @(negedge clk);
            rdy = u_if.in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        if (!rdy) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout %s: in_ready never 1 (got 0 expected 1)", v.name);
        end
        u_if.in_valid = 1'b0;
    endtask

    // Monitor: checks counter, read ports and the commit bus on every negedge.
    always @(negedge clk) begin
        exp_t e;
        bit   cv;
        if (rst_n) begin
            chk("instret", instret, exp_instret);
            cv = commit_valid;
            e  = '0;
            if (cv) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL commit_unexpected: got commit_valid=1 expected 0");
                end else begin
                    e = sb_q.pop_front();
                    chk("commit_pc", commit_pc, e.pc);
                    chk("commit_data", commit_data, e.data);
                    chk("commit_wen", {63'd0, commit_wen}, {63'd0, e.wen});
                    if (e.wen) chk("commit_rd", {59'd0, commit_rd}, {59'd0, e.rd});
                end
            end
            chk("rdata1", rdata1, model_read(raddr1, e, cv));
            chk("rdata2", rdata2, model_read(raddr2, e, cv));
            if (cv && e.wen) sh[e.rd] = e.data;
            if (cv) exp_instret = exp_instret + 64'd1;
        end
    end

    initial begin
        logic [63:0] base;
        n_checks = 0;
        n_errors = 0;
        exp_instret = 64'd0;
        for (int i = 0; i < 32; i++) sh[i] = 64'd0;
        rst_n = 1'b0; hold = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        u_if.in_valid = 1'b0; u_if.in_pc = 64'd0; u_if.in_alu = 64'd0;
        u_if.in_mem = 64'd0; u_if.in_csr = 64'd0; u_if.in_wbsel = 2'd0;
        u_if.in_size = 2'd0; u_if.in_unsigned = 1'b0; u_if.in_regwr = 1'b0;
        u_if.in_rd = 5'd0;

        tbl[0]  = mk("alu",      2'd0, 2'd0, 1'b0, 1'b1, 5'd5,  64'h100, 64'h1234, 64'd0, 64'd0, 64'h1234);
        tbl[1]  = mk("lb_s",     2'd1, 2'd0, 1'b0, 1'b1, 5'd6,  64'h104, 64'd0, 64'h80, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
        tbl[2]  = mk("lbu",      2'd1, 2'd0, 1'b1, 1'b1, 5'd8,  64'h108, 64'd0, 64'h80, 64'd0, 64'h80);
        tbl[3]  = mk("lw_s",     2'd1, 2'd2, 1'b0, 1'b1, 5'd9,  64'h10C, 64'd0, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000);
        tbl[4]  = mk("pc4",      2'd2, 2'd0, 1'b0, 1'b1, 5'd10, 64'h8000_0000, 64'd0, 64'd0, 64'd0, 64'h8000_0004);
        tbl[5]  = mk("csr",      2'd3, 2'd0, 1'b0, 1'b1, 5'd11, 64'h110, 64'd0, 64'd0, 64'hABCD, 64'hABCD);
        tbl[6]  = mk("x0",       2'd0, 2'd0, 1'b0, 1'b1, 5'd0,  64'h114, 64'hDEAD, 64'd0, 64'd0, 64'hDEAD);
        tbl[7]  = mk("lh_s",     2'd1, 2'd1, 1'b0, 1'b1, 5'd12, 64'h118, 64'd0, 64'h1234_F00F, 64'd0, 64'hFFFF_FFFF_FFFF_F00F);
        tbl[8]  = mk("ld",       2'd1, 2'd3, 1'b0, 1'b1, 5'd13, 64'h11C, 64'd0, 64'h8765_4321_0000_0001, 64'd0, 64'h8765_4321_0000_0001);
        tbl[9]  = mk("lwu",      2'd1, 2'd2, 1'b1, 1'b1, 5'd14, 64'h120, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'h8000_0000);
        tbl[10] = mk("noregwr",  2'd0, 2'd0, 1'b0, 1'b0, 5'd15, 64'h124, 64'd5, 64'd0, 64'd0, 64'd5);
        tbl[11] = mk("pc4_wrap", 2'd2, 2'd0, 1'b0, 1'b1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 64'd0, 64'd0);

        // Reset state.
        #3;
        chk("rst_instret", instret, 64'd0);
        chk("rst_in_ready", {63'd0, u_if.in_ready}, 64'd1);
        chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("rst_commit_wen", {63'd0, commit_wen}, 64'd0);
        chk("rst_commit_pc", commit_pc, 64'd0);
        chk("rst_commit_data", commit_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven stream of retiring instructions, back to back.
        for (int i = 0; i < 12; i++) send(tbl[i]);
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            @(posedge clk); #1;
        end
        raddr1 = 5'd5; raddr2 = 5'd0; #1;
        chk("x5_readback", rdata1, 64'h1234);
        chk("x0_readback", rdata2, 64'd0);
        chk("instret_after_table", instret, 64'd12);

        // Hold with an entry present.
        raddr1 = 5'd21; raddr2 = 5'd22;
        send(mk("held_a", 2'd0, 2'd0, 1'b0, 1'b1, 5'd21, 64'h200, 64'hA1, 64'd0, 64'd0, 64'hA1));
        hold = 1'b1;
        base = exp_instret;
        u_if.in_valid = 1'b1; u_if.in_pc = 64'h204; u_if.in_alu = 64'hB2;
        u_if.in_wbsel = 2'd0; u_if.in_regwr = 1'b1; u_if.in_rd = 5'd22;
        sb_q.push_back('{pc: 64'h204, data: 64'hB2, wen: 1'b1, rd: 5'd22});
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", {63'd0, u_if.in_ready}, 64'd0);
            chk("hold_commit_valid", {63'd0, commit_valid}, 64'd0);
            chk("hold_instret", instret, base);
            chk("hold_no_write", rdata1, 64'd0);
        end
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        chk("release_in_ready", {63'd0, u_if.in_ready}, 64'd1);
        chk("release_commit_valid", {63'd0, commit_valid}, 64'd1);
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        @(negedge clk);
        chk("release_one_count", instret, base + 64'd1);
        chk("release_one_write", rdata1, 64'hA1);
        @(posedge clk); #1;

        // Reset mid-cycle with a pending held entry.
        send(mk("lost", 2'd0, 2'd0, 1'b0, 1'b1, 5'd20, 64'h300, 64'h5555, 64'd0, 64'd0, 64'h5555));
        hold = 1'b1;
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        exp_instret = 64'd0;
        for (int i = 0; i < 32; i++) sh[i] = 64'd0;
        #1;
        chk("mrst_instret", instret, 64'd0);
        chk("mrst_in_ready", {63'd0, u_if.in_ready}, 64'd1);
        chk("mrst_commit_valid", {63'd0, commit_valid}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            chk("mrst_rdata1", rdata1, 64'd0);
            chk("mrst_rdata2", rdata2, 64'd0);
        end
        hold = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back writes to x7. The read checks in the monitor expect
        // same-cycle bypass or a one-cycle lag, depending on BYP.
        raddr1 = 5'd7; raddr2 = 5'd7;
        for (int k = 1; k <= 4; k++) begin
            send(mk("x7_stream", 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 64'(32'h400 + 4 * k),
                    64'(k), 64'd0, 64'd0, 64'(k)));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("final_instret", instret, 64'd4);
        chk("final_x7", rdata1, 64'd4);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
